// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - round-robin owner of the 8:1 mux select; optional forced release under `ifdef ARB_TIMEOUT_EN
module mux_sel_arbiter #(
    parameter int unsigned NREQ     = 8,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic             busy,
    output logic             timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [NREQ-1:0]  others_w;
    logic             owner_req_w;
    logic             force_w;
    logic             release_w;
    logic [SEL_W-1:0] after_owner_w;
    logic [SEL_W-1:0] search_from_w;
    logic [SEL_W:0]   pick_w;
    logic             new_grant_w;

    // First set bit of r at or above start, wrapping; MSB of result flags a hit.
    function automatic logic [SEL_W:0] rr_pick(input logic [NREQ-1:0]  r,
                                               input logic [SEL_W-1:0] start);
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = start + SEL_W'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Candidate set excludes the current owner; in IDLE gnt_q is zero so this is just req.
    always_comb begin
        others_w      = req & ~gnt_q;
        owner_req_w   = |(req & gnt_q);
        after_owner_w = sel_q + SEL_W'(1);
        release_w     = (state_q == OWN) && (!owner_req_w || force_w);
        search_from_w = (state_q == OWN) ? after_owner_w : ptr_q;
        pick_w        = rr_pick(others_w, search_from_w);
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    // Forced release only when someone else is waiting; a lone owner keeps the mux.
    always_comb begin
        force_w = (state_q == OWN) && owner_req_w &&
                  (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) && (|others_w);
    end

    // Count owner cycles, restart on every new grant, saturate at MAX_HOLD-1.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (new_grant_w) begin
            hold_cnt_d = '0;
        end else if ((state_q == OWN) && (hold_cnt_q != HOLD_W'(MAX_HOLD - 1))) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign timeout = force_w;
`else
    assign force_w = 1'b0;
    assign timeout = 1'b0;
`endif

    // Next-state: grant from IDLE, or on owner release hand over back-to-back or drop to IDLE.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        new_grant_w = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_w[SEL_W]) begin
                    state_d     = OWN;
                    gnt_d       = NREQ'(1) << pick_w[SEL_W-1:0];
                    sel_d       = pick_w[SEL_W-1:0];
                    new_grant_w = 1'b1;
                end
            end
            OWN: begin
                if (release_w) begin
                    ptr_d = after_owner_w;
                    if (pick_w[SEL_W]) begin
                        gnt_d       = NREQ'(1) << pick_w[SEL_W-1:0];
                        sel_d       = pick_w[SEL_W-1:0];
                        new_grant_w = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State, grant, select and pointer registers; reset clears them immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign sel_valid = (state_q == OWN);
    assign busy      = (state_q == OWN);

endmodule
